// File: rtl/or1k_spr_pkg.sv
// Shared types and constants for the OR1K SPR bus initiator.
// Holds the FSM encoding, requester ownership and SPR group helpers.
package or1k_spr_pkg;

  typedef enum logic [1:0] {
    SPR_IDLE   = 2'd0,
    SPR_ACCESS = 2'd1,
    SPR_RESP   = 2'd2
  } spr_state_e;

  typedef enum logic {
    OWNER_CTRL = 1'b0,
    OWNER_DU   = 1'b1
  } spr_owner_e;

  localparam int unsigned OR1K_SPR_GRP_SYS = 0;
  localparam int unsigned OR1K_SPR_GRP_PIC = 9;
  localparam int unsigned OR1K_SPR_GRP_TT  = 10;

  function automatic logic [4:0] SPR_GROUP(input logic [15:0] addr);
    return addr[15:11];
  endfunction

endpackage

// File: rtl/or1k_spr_group_decode.sv
// Combinational SPR group decode: one-hot strobe, presence flag and the
// ack / read-data mux for the selected group.
module or1k_spr_group_decode
  import or1k_spr_pkg::*;
#(
  parameter int          NUM_GROUPS    = 32,
  parameter logic [31:0] GROUP_PRESENT = 32'h0000_0201
) (
  input  logic [4:0]               group,
  input  logic [NUM_GROUPS-1:0]    spr_bus_ack,
  input  logic [32*NUM_GROUPS-1:0] spr_dat,
  output logic [NUM_GROUPS-1:0]    onehot,
  output logic                     valid,
  output logic                     ack_sel,
  output logic [31:0]              dat_sel
);

  logic [31:0] grp_idx;

  assign grp_idx = {27'd0, group};
  assign valid   = (grp_idx < 32'(NUM_GROUPS)) && GROUP_PRESENT[group];

  always_comb begin
    onehot  = '0;
    ack_sel = 1'b0;
    dat_sel = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (valid && (grp_idx == 32'(g))) begin
        onehot[g] = 1'b1;
        ack_sel   = spr_bus_ack[g];
        dat_sel   = spr_dat[32*g +: 32];
      end
    end
  end

endmodule

// File: rtl/or1k_spr_master.sv
// SPR bus initiator: arbitrates ctrl/du requests, strobes one SPR group,
// waits for its ack (bounded by TIMEOUT) and returns data/err to the owner.
//
// state      | meaning
// SPR_IDLE   | arbitrate, latch winning request
// SPR_ACCESS | strobe selected group, count toward timeout
// SPR_RESP   | one-cycle done pulse to the owner, clear counter
module or1k_spr_master
  import or1k_spr_pkg::*;
#(
  parameter int          NUM_GROUPS    = 32,
  parameter logic [31:0] GROUP_PRESENT = 32'h0000_0201,
  parameter int          TIMEOUT       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ctrl_req_i,
  input  logic                     ctrl_we_i,
  input  logic [15:0]              ctrl_addr_i,
  input  logic [31:0]              ctrl_dat_i,
  output logic                     ctrl_done_o,
  output logic [31:0]              ctrl_dat_o,
  output logic                     ctrl_err_o,
  input  logic                     du_req_i,
  input  logic                     du_we_i,
  input  logic [15:0]              du_addr_i,
  input  logic [31:0]              du_dat_i,
  output logic                     du_done_o,
  output logic [31:0]              du_dat_o,
  output logic                     du_err_o,
  output logic [NUM_GROUPS-1:0]    spr_access_o,
  output logic                     spr_we_o,
  output logic [15:0]              spr_addr_o,
  output logic [31:0]              spr_dat_o,
  input  logic [NUM_GROUPS-1:0]    spr_bus_ack_i,
  input  logic [32*NUM_GROUPS-1:0] spr_dat_i
);

  localparam int CW = $clog2(TIMEOUT + 1);

  spr_state_e        state_q, state_d;
  spr_owner_e        owner_q, owner_d;
  logic              we_q, we_d;
  logic [15:0]       addr_q, addr_d;
  logic [31:0]       dat_q, dat_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              prio_ctrl_q, prio_ctrl_d;
  logic              rsp_upd, rsp_err;
  logic [31:0]       rsp_dat;
  logic [31:0]       ctrl_dat_q, du_dat_q;
  logic              ctrl_err_q, du_err_q;

  logic [NUM_GROUPS-1:0] grp_onehot;
  logic                  grp_valid, grp_ack;
  logic [31:0]           grp_dat;

  or1k_spr_group_decode #(
    .NUM_GROUPS   (NUM_GROUPS),
    .GROUP_PRESENT(GROUP_PRESENT)
  ) u_decode (
    .group      (SPR_GROUP(addr_q)),
    .spr_bus_ack(spr_bus_ack_i),
    .spr_dat    (spr_dat_i),
    .onehot     (grp_onehot),
    .valid      (grp_valid),
    .ack_sel    (grp_ack),
    .dat_sel    (grp_dat)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    dat_d       = dat_q;
    cnt_d       = cnt_q;
    prio_ctrl_d = prio_ctrl_q;
    rsp_upd     = 1'b0;
    rsp_err     = 1'b0;
    rsp_dat     = '0;
    case (state_q)
      SPR_IDLE: begin
        // ctrl gets one shot right after a du completion so du cannot starve it
        prio_ctrl_d = 1'b0;
        if (du_req_i && !(prio_ctrl_q && ctrl_req_i)) begin
          owner_d = OWNER_DU;
          we_d    = du_we_i;
          addr_d  = du_addr_i;
          dat_d   = du_dat_i;
          state_d = SPR_ACCESS;
        end else if (ctrl_req_i) begin
          owner_d = OWNER_CTRL;
          we_d    = ctrl_we_i;
          addr_d  = ctrl_addr_i;
          dat_d   = ctrl_dat_i;
          state_d = SPR_ACCESS;
        end
      end
      SPR_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (!grp_valid) begin
          rsp_upd = 1'b1;
          rsp_err = 1'b1;
          state_d = SPR_RESP;
        end else if (grp_ack) begin
          rsp_upd = 1'b1;
          rsp_dat = we_q ? 32'd0 : grp_dat;
          state_d = SPR_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_upd = 1'b1;
          rsp_err = 1'b1;
          state_d = SPR_RESP;
        end
      end
      SPR_RESP: begin
        cnt_d       = '0;
        prio_ctrl_d = (owner_q == OWNER_DU);
        state_d     = SPR_IDLE;
      end
      default: state_d = SPR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SPR_IDLE;
      owner_q     <= OWNER_CTRL;
      we_q        <= 1'b0;
      addr_q      <= '0;
      dat_q       <= '0;
      cnt_q       <= '0;
      prio_ctrl_q <= 1'b0;
      ctrl_dat_q  <= '0;
      ctrl_err_q  <= 1'b0;
      du_dat_q    <= '0;
      du_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      dat_q       <= dat_d;
      cnt_q       <= cnt_d;
      prio_ctrl_q <= prio_ctrl_d;
      if (rsp_upd && owner_q == OWNER_DU) begin
        du_dat_q <= rsp_dat;
        du_err_q <= rsp_err;
      end else if (rsp_upd) begin
        ctrl_dat_q <= rsp_dat;
        ctrl_err_q <= rsp_err;
      end
    end
  end

  // Bus outputs are quiet outside ACCESS; read cycles never expose write data.
  assign spr_access_o = (state_q == SPR_ACCESS) ? grp_onehot : '0;
  assign spr_we_o     = (state_q == SPR_ACCESS) && we_q;
  assign spr_addr_o   = (state_q == SPR_ACCESS) ? addr_q : 16'd0;
  assign spr_dat_o    = (state_q == SPR_ACCESS && we_q) ? dat_q : 32'd0;

  assign ctrl_done_o = (state_q == SPR_RESP) && (owner_q == OWNER_CTRL);
  assign du_done_o   = (state_q == SPR_RESP) && (owner_q == OWNER_DU);
  assign ctrl_dat_o  = ctrl_dat_q;
  assign ctrl_err_o  = ctrl_err_q;
  assign du_dat_o    = du_dat_q;
  assign du_err_o    = du_err_q;

endmodule

// File: tb/tb_or1k_spr_master.sv
// Directed bench for or1k_spr_master: vector table for single accesses plus
// hand sequences for arbitration, timeout, late ack and mid-access reset.
module tb_or1k_spr_master;

  logic         clk = 1'b0;
  logic         rst;
  logic         ctrl_req, ctrl_we, du_req, du_we;
  logic [15:0]  ctrl_addr, du_addr;
  logic [31:0]  ctrl_wdat, du_wdat;
  logic         ctrl_done, ctrl_err, du_done, du_err;
  logic [31:0]  ctrl_rdat, du_rdat;
  logic [31:0]  spr_access, spr_ack;
  logic         spr_we;
  logic [15:0]  spr_addr;
  logic [31:0]  spr_wdat;
  logic [1023:0] spr_rdat_bus;
  logic         ack_en;
  logic [31:0]  noise_ack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb spr_ack = (ack_en ? spr_access : 32'd0) | noise_ack;

  or1k_spr_master dut (
    .clk(clk), .rst(rst),
    .ctrl_req_i(ctrl_req), .ctrl_we_i(ctrl_we), .ctrl_addr_i(ctrl_addr), .ctrl_dat_i(ctrl_wdat),
    .ctrl_done_o(ctrl_done), .ctrl_dat_o(ctrl_rdat), .ctrl_err_o(ctrl_err),
    .du_req_i(du_req), .du_we_i(du_we), .du_addr_i(du_addr), .du_dat_i(du_wdat),
    .du_done_o(du_done), .du_dat_o(du_rdat), .du_err_o(du_err),
    .spr_access_o(spr_access), .spr_we_o(spr_we), .spr_addr_o(spr_addr), .spr_dat_o(spr_wdat),
    .spr_bus_ack_i(spr_ack), .spr_dat_i(spr_rdat_bus)
  );

  typedef struct {
    logic        du;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdat;
    logic [31:0] rslice;
    logic [31:0] exp_strobe;
    logic        exp_err;
    logic [31:0] exp_rdat;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_bus(input logic [15:0] addr, input logic [31:0] val);
    logic [4:0] g;
    g = addr[15:11];
    for (int i = 0; i < 32; i++) spr_rdat_bus[32*i +: 32] = 32'h1000_0000 + i;
    spr_rdat_bus[32*g +: 32] = val;
  endtask

  task automatic idle_inputs();
    ctrl_req = 0; ctrl_we = 0; ctrl_addr = 0; ctrl_wdat = 0;
    du_req = 0; du_we = 0; du_addr = 0; du_wdat = 0;
  endtask

  initial begin
    vecs[0] = '{du: 0, we: 1, addr: 16'h4800, wdat: 32'h0000_00F0, rslice: 32'h5555_5555,
                exp_strobe: 32'h0000_0200, exp_err: 0, exp_rdat: 32'h0};
    vecs[1] = '{du: 0, we: 0, addr: 16'h4802, wdat: 32'hFFFF_FFFF, rslice: 32'h0000_0010,
                exp_strobe: 32'h0000_0200, exp_err: 0, exp_rdat: 32'h10};
    vecs[2] = '{du: 1, we: 0, addr: 16'h0011, wdat: 32'h0, rslice: 32'hDEAD_BEEF,
                exp_strobe: 32'h0000_0001, exp_err: 0, exp_rdat: 32'hDEAD_BEEF};
    vecs[3] = '{du: 0, we: 0, addr: 16'h2800, wdat: 32'h0, rslice: 32'h1234_5678,
                exp_strobe: 32'h0, exp_err: 1, exp_rdat: 32'h0};
    vecs[4] = '{du: 1, we: 1, addr: 16'hF800, wdat: 32'hAAAA_0000, rslice: 32'h9999_9999,
                exp_strobe: 32'h0, exp_err: 1, exp_rdat: 32'h0};
    vecs[5] = '{du: 1, we: 0, addr: 16'h5000, wdat: 32'h0, rslice: 32'h7777_7777,
                exp_strobe: 32'h0, exp_err: 1, exp_rdat: 32'h0};

    idle_inputs();
    ack_en = 0; noise_ack = 0; spr_rdat_bus = '0;
    rst = 1;
    step(); step();
    check("rst_strobe", 64'(spr_access), 64'h0);
    check("rst_done", {62'd0, ctrl_done, du_done}, 64'h0);
    check("rst_dat", {ctrl_rdat, du_rdat}, 64'h0);
    check("rst_err", {62'd0, ctrl_err, du_err}, 64'h0);
    check("rst_bus", {15'd0, spr_we, spr_addr, spr_wdat}, 64'h0);
    rst = 0;
    step();

    for (int v = 0; v < 6; v++) begin
      set_bus(vecs[v].addr, vecs[v].rslice);
      ack_en = 1;
      if (vecs[v].du) begin
        du_req = 1; du_we = vecs[v].we; du_addr = vecs[v].addr; du_wdat = vecs[v].wdat;
      end else begin
        ctrl_req = 1; ctrl_we = vecs[v].we; ctrl_addr = vecs[v].addr; ctrl_wdat = vecs[v].wdat;
      end
      step();
      check($sformatf("v%0d_strobe", v), 64'(spr_access), 64'(vecs[v].exp_strobe));
      if (vecs[v].exp_strobe != 0) begin
        check($sformatf("v%0d_we", v), 64'(spr_we), 64'(vecs[v].we));
        check($sformatf("v%0d_addr", v), 64'(spr_addr), 64'(vecs[v].addr));
        check($sformatf("v%0d_wdat", v), 64'(spr_wdat), vecs[v].we ? 64'(vecs[v].wdat) : 64'h0);
      end
      check($sformatf("v%0d_nodone_c1", v), {62'd0, ctrl_done, du_done}, 64'h0);
      step();
      if (vecs[v].du) begin
        check($sformatf("v%0d_done", v), {62'd0, ctrl_done, du_done}, 64'h1);
        check($sformatf("v%0d_rdat", v), 64'(du_rdat), 64'(vecs[v].exp_rdat));
        check($sformatf("v%0d_err", v), 64'(du_err), 64'(vecs[v].exp_err));
      end else begin
        check($sformatf("v%0d_done", v), {62'd0, ctrl_done, du_done}, 64'h2);
        check($sformatf("v%0d_rdat", v), 64'(ctrl_rdat), 64'(vecs[v].exp_rdat));
        check($sformatf("v%0d_err", v), 64'(ctrl_err), 64'(vecs[v].exp_err));
      end
      check($sformatf("v%0d_strobe_resp", v), 64'(spr_access), 64'h0);
      idle_inputs();
      step();
      check($sformatf("v%0d_idle", v), {30'd0, ctrl_done, du_done, spr_access}, 64'h0);
    end
    step();

    // Contention: du first, then ctrl despite du still requesting.
    set_bus(16'h0011, 32'hCAFE_0001);
    ack_en = 1;
    ctrl_req = 1; ctrl_we = 1; ctrl_addr = 16'h4800; ctrl_wdat = 32'h0000_00F0;
    du_req = 1; du_we = 0; du_addr = 16'h0011;
    step();
    check("arb_first_strobe", 64'(spr_access), 64'h1);
    check("arb_first_addr", 64'(spr_addr), 64'h0011);
    step();
    check("arb_first_done", {62'd0, ctrl_done, du_done}, 64'h1);
    check("arb_first_rdat", 64'(du_rdat), 64'hCAFE_0001);
    step();
    check("arb_idle_strobe", 64'(spr_access), 64'h0);
    step();
    check("arb_second_strobe", 64'(spr_access), 64'h200);
    check("arb_second_addr", 64'(spr_addr), 64'h4800);
    check("arb_second_wdat", 64'(spr_wdat), 64'hF0);
    step();
    check("arb_second_done", {62'd0, ctrl_done, du_done}, 64'h2);
    check("arb_second_err", 64'(ctrl_err), 64'h0);
    idle_inputs();
    step();
    step();

    // Timeout: no ack from group 9, a stray ack on group 0 must be ignored.
    ack_en = 0; noise_ack = 32'h1;
    ctrl_req = 1; ctrl_we = 0; ctrl_addr = 16'h4802;
    step();
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("to_strobe_%0d", i), {31'd0, ctrl_done, spr_access}, 64'h200);
      step();
    end
    check("to_done", {62'd0, ctrl_done, du_done}, 64'h2);
    check("to_err", 64'(ctrl_err), 64'h1);
    check("to_rdat", 64'(ctrl_rdat), 64'h0);
    idle_inputs();
    noise_ack = 0;
    step();

    // Ack lands exactly on the last ACCESS cycle before timeout.
    set_bus(16'h4802, 32'h0000_0ABC);
    ctrl_req = 1; ctrl_we = 0; ctrl_addr = 16'h4802;
    step();
    for (int i = 1; i <= 15; i++) step();
    check("late_strobe16", {31'd0, ctrl_done, spr_access}, 64'h200);
    ack_en = 1;
    step();
    check("late_done", {62'd0, ctrl_done, du_done}, 64'h2);
    check("late_err", 64'(ctrl_err), 64'h0);
    check("late_rdat", 64'(ctrl_rdat), 64'hABC);
    idle_inputs();
    ack_en = 0;
    step();

    // Reset in the middle of an access.
    ctrl_req = 1; ctrl_we = 1; ctrl_addr = 16'h4800; ctrl_wdat = 32'h33;
    step();
    step();
    check("mid_strobe", 64'(spr_access), 64'h200);
    rst = 1;
    idle_inputs();
    step();
    check("mid_rst_strobe", 64'(spr_access), 64'h0);
    check("mid_rst_done", {62'd0, ctrl_done, du_done}, 64'h0);
    check("mid_rst_dat", 64'(ctrl_rdat), 64'h0);
    rst = 0;
    step();
    check("mid_after_done", {62'd0, ctrl_done, du_done}, 64'h0);
    set_bus(16'h4802, 32'h0000_0010);
    ack_en = 1;
    ctrl_req = 1; ctrl_we = 0; ctrl_addr = 16'h4802;
    step();
    check("post_strobe", 64'(spr_access), 64'h200);
    check("post_wdat", 64'(spr_wdat), 64'h0);
    step();
    check("post_done", {62'd0, ctrl_done, du_done}, 64'h2);
    check("post_rdat", 64'(ctrl_rdat), 64'h10);
    check("post_err", 64'(ctrl_err), 64'h0);
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
